// File: rtl/code_lock_fsm.sv
// Keypad sequence lock. Accepts one digit per rising edge of insert and tracks progress
// through a CODE_LEN-digit secret. Wrong digits are forgiven LIVES times, and an optional idle timeout is supported.
//
// state    | meaning
// ---------+------------------------------------------------
// ENTRY    | accepting digits, progress counts correct ones
// UNLOCKED | full code entered; sticky until reset
// FAILED   | ran out of lives; sticky until reset
module code_lock_fsm #(
   parameter int                          CODE_LEN  = 6,
   parameter int                          DIGIT_W   = 4,
   parameter int                          MAX_DIGIT = 9,
   parameter logic [CODE_LEN*DIGIT_W-1:0] CODE      = 24'h959735,
   parameter int                          LIVES     = 1,
   parameter int                          TIMEOUT   = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               insert,
   output logic [3:0]         progress,
   output logic [2:0]         lives_left,
   output logic               unlocked,
   output logic               failed,
   output logic [6:0]         seg
);

   localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {ST_ENTRY, ST_UNLOCKED, ST_FAILED} state_t;

   state_t             state_q, state_d;
   logic [3:0]         progress_q, progress_d;
   logic [2:0]         lives_q, lives_d;
   logic [6:0]         seg_q, seg_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               insert_q;
   logic               ev, ev_valid, tmr_dec, expire;
   logic [3:0]         prog_eff;
   logic [DIGIT_W-1:0] exp_digit;

   function automatic logic [6:0] seg_of(input logic [DIGIT_W-1:0] d);
      case (int'(d))
         0:       return 7'b0000001;
         1:       return 7'b1001111;
         2:       return 7'b0010010;
         3:       return 7'b0000110;
         4:       return 7'b1001100;
         5:       return 7'b0100100;
         6:       return 7'b0100000;
         7:       return 7'b0001111;
         8:       return 7'b0000000;
         9:       return 7'b0000100;
         default: return 7'b1111110;
      endcase
   endfunction

   always_comb begin
      ev       = insert & ~insert_q;
      ev_valid = ev & (digit <= DIGIT_W'(MAX_DIGIT));
      // Idle timer runs down from TIMEOUT; hitting terminal count clears progress.
      tmr_dec  = (state_q == ST_ENTRY) && (progress_q != 4'd0) && (tmr_q != '0);
      expire   = tmr_dec && (tmr_q == TMR_W'(1));
      prog_eff = expire ? 4'd0 : progress_q;

      exp_digit = '0;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (prog_eff == 4'(k)) exp_digit = CODE[k*DIGIT_W +: DIGIT_W];
      end

      state_d    = state_q;
      progress_d = prog_eff;
      lives_d    = lives_q;
      seg_d      = expire ? 7'b0000001 : seg_q;
      tmr_d      = tmr_dec ? tmr_q - TMR_W'(1) : tmr_q;

      if (ev_valid) begin
         tmr_d = TMR_W'(TIMEOUT);
         if (state_q == ST_ENTRY) begin
            seg_d = seg_of(digit);
            if (digit == exp_digit) begin
               progress_d = prog_eff + 4'd1;
               if (prog_eff + 4'd1 == 4'(CODE_LEN)) state_d = ST_UNLOCKED;
            end else if (lives_q != 3'd0) begin
               lives_d = lives_q - 3'd1;
            end else begin
               state_d = ST_FAILED;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ENTRY;
         progress_q <= 4'd0;
         lives_q    <= 3'(LIVES);
         seg_q      <= 7'b0000001;
         tmr_q      <= TMR_W'(TIMEOUT);
         insert_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         progress_q <= progress_d;
         lives_q    <= lives_d;
         seg_q      <= seg_d;
         tmr_q      <= tmr_d;
         insert_q   <= insert;
      end
   end

   always_comb begin
      seg = seg_q;
      if (state_q == ST_FAILED) seg = 7'b0111000;
      else if (state_q == ST_UNLOCKED) seg = (lives_q == 3'(LIVES)) ? 7'b0100100 : 7'b0011000;
   end

   assign progress   = progress_q;
   assign lives_left = lives_q;
   assign unlocked   = (state_q == ST_UNLOCKED);
   assign failed     = (state_q == ST_FAILED);

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm: a default lock and a TIMEOUT=8 lock share the same stimulus.
// Both are checked every cycle against a digit-level reference model.
module tb_code_lock_fsm;

   logic       clk = 1'b0;
   logic       reset, insert;
   logic [3:0] digit;
   logic [3:0] progress0, progress1;
   logic [2:0] lives0, lives1;
   logic       unlocked0, unlocked1, failed0, failed1;
   logic [6:0] seg0, seg1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   code_lock_fsm dut0 (
      .clk(clk), .reset(reset), .digit(digit), .insert(insert),
      .progress(progress0), .lives_left(lives0), .unlocked(unlocked0),
      .failed(failed0), .seg(seg0));

   code_lock_fsm #(.TIMEOUT(8)) dut1 (
      .clk(clk), .reset(reset), .digit(digit), .insert(insert),
      .progress(progress1), .lives_left(lives1), .unlocked(unlocked1),
      .failed(failed1), .seg(seg1));

   // Reference model: mode 0 = entering, 1 = unlocked, 2 = failed.
   int         code_dig [6] = '{5, 3, 7, 9, 5, 9};
   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   int         tmo [2] = '{0, 8};
   int         m_prog [2], m_lives [2], m_mode [2], m_idle [2];
   logic [6:0] m_seg [2];
   bit         ins_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit ins, input int dg);
      bit valid;
      valid = ins && !ins_prev && (dg <= 9);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_mode[i] = 0; m_prog[i] = 0; m_lives[i] = 1; m_idle[i] = 0;
            m_seg[i] = seg_tab[0];
         end else begin
            if (m_mode[i] == 0 && tmo[i] > 0 && m_prog[i] > 0) begin
               if (m_idle[i] < tmo[i]) m_idle[i]++;
               if (m_idle[i] == tmo[i]) begin
                  m_prog[i] = 0;
                  m_seg[i] = seg_tab[0];
               end
            end
            if (valid) begin
               m_idle[i] = 0;
               if (m_mode[i] == 0) begin
                  m_seg[i] = seg_tab[dg];
                  if (dg == code_dig[m_prog[i]]) begin
                     m_prog[i]++;
                     if (m_prog[i] == 6) m_mode[i] = 1;
                  end else if (m_lives[i] > 0) begin
                     m_lives[i]--;
                  end else begin
                     m_mode[i] = 2;
                  end
               end
            end
         end
      end
      ins_prev = rst ? 1'b0 : ins;
   endtask

   function automatic logic [6:0] exp_seg(input int i);
      if (m_mode[i] == 2) return 7'b0111000;
      if (m_mode[i] == 1) return (m_lives[i] == 1) ? 7'b0100100 : 7'b0011000;
      return m_seg[i];
   endfunction

   task automatic compare_all();
      check("progress0", 32'(progress0), 32'(m_prog[0]));
      check("lives0",    32'(lives0),    32'(m_lives[0]));
      check("unlocked0", 32'(unlocked0), 32'(m_mode[0] == 1));
      check("failed0",   32'(failed0),   32'(m_mode[0] == 2));
      check("seg0",      32'(seg0),      32'(exp_seg(0)));
      check("progress1", 32'(progress1), 32'(m_prog[1]));
      check("lives1",    32'(lives1),    32'(m_lives[1]));
      check("unlocked1", 32'(unlocked1), 32'(m_mode[1] == 1));
      check("failed1",   32'(failed1),   32'(m_mode[1] == 2));
      check("seg1",      32'(seg1),      32'(exp_seg(1)));
   endtask

   task automatic tick(input bit rst, input bit ins, input int dg);
      reset  = rst;
      insert = ins;
      digit  = 4'(dg);
      @(posedge clk);
      model_step(rst, ins, dg);
      #1;
      compare_all();
   endtask

   task automatic press(input int dg);
      tick(1'b0, 1'b1, dg);
      tick(1'b0, 1'b0, dg);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 0);
   endtask

   initial begin
      int r, d, hold;
      reset = 1'b1; insert = 1'b0; digit = 4'd0;
      ins_prev = 1'b0;
      #2;
      tick(1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, 0);
      check("rst_progress", 32'(progress0), 32'd0);
      check("rst_lives",    32'(lives0),    32'd1);
      check("rst_seg",      32'(seg0),      32'h01);
      check("rst_flags",    32'({unlocked0, failed0}), 32'd0);

      // Straight correct code
      foreach (code_dig[k]) press(code_dig[k]);
      check("s1_unlocked", 32'(unlocked0), 32'd1);
      check("s1_seg",      32'(seg0),      32'b0100100);

      // One forgiven mistake
      tick(1'b1, 1'b0, 0);
      press(5); press(3); press(2);
      check("s2_lives_after_wrong", 32'(lives0),    32'd0);
      check("s2_progress_held",     32'(progress0), 32'd2);
      press(7); press(9); press(5); press(9);
      check("s2_unlocked", 32'(unlocked0), 32'd1);
      check("s2_seg",      32'(seg0),      32'b0011000);

      // Run out of lives
      tick(1'b1, 1'b0, 0);
      press(5); press(1); press(1);
      check("s3_failed", 32'(failed0), 32'd1);
      check("s3_seg",    32'(seg0),    32'b0111000);
      press(3);
      check("s3_sticky", 32'(progress0), 32'd1);

      // Held insert and an out-of-range digit
      tick(1'b1, 1'b0, 0);
      repeat (10) tick(1'b0, 1'b1, 5);
      tick(1'b0, 1'b0, 5);
      check("s4_hold_one_event", 32'(progress0), 32'd1);
      press(12);
      check("s4_bad_digit_prog", 32'(progress0), 32'd1);
      check("s4_bad_digit_seg",  32'(seg0),      32'b0100100);

      // Idle timeout on the TIMEOUT=8 instance
      tick(1'b1, 1'b0, 0);
      press(5); press(3);
      idle(6);
      check("s5_before_expiry", 32'(progress1), 32'd2);
      idle(1);
      check("s5_expired_prog",  32'(progress1), 32'd0);
      check("s5_expired_lives", 32'(lives1),    32'd1);
      check("s5_expired_seg",   32'(seg1),      32'h01);
      foreach (code_dig[k]) press(code_dig[k]);
      check("s5_unlocked", 32'(unlocked1), 32'd1);

      // Reset colliding with an insert edge mid-entry
      tick(1'b1, 1'b0, 0);
      press(5); press(3); press(7);
      tick(1'b1, 1'b1, 9);
      check("s6_rst_prog",  32'(progress0), 32'd0);
      check("s6_rst_lives", 32'(lives0),    32'd1);
      check("s6_rst_seg",   32'(seg0),      32'h01);
      tick(1'b0, 1'b0, 0);

      // Randomized sessions
      repeat (400) begin
         if ((m_mode[0] != 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 24) == 0)
            tick(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
         idle(int'($urandom_range(0, 10)));
         r = int'($urandom_range(0, 7));
         if (r < 5)       d = code_dig[(m_prog[0] < 6) ? m_prog[0] : 0];
         else if (r == 5) d = int'($urandom_range(10, 15));
         else             d = int'($urandom_range(0, 9));
         hold = int'($urandom_range(1, 3));
         repeat (hold) tick(1'b0, 1'b1, d);
         tick(1'b0, 1'b0, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
